apb_ethernet_rx_buffer_x32: RTL and testbench

Single-clock receive frame buffer between a 32-bit Ethernet RX stream (already in the APB clock domain, after the MAC-side CDC) and an APB completer polled by the management MCU over QSPI/APB. It stores complete frames in a circular word buffer and publishes each committed frame's byte length through a small length FIFO. Software reads the head frame by address, then pops it. Frames that do not fit, or that the MAC flags bad, are discarded atomically.

---
 rtl/apb_ethernet_rx_buffer_x32_if.sv | 19 +
 rtl/apb_ethernet_rx_buffer_x32.sv | 179 +++++++++++++++++
 tb/tb_apb_ethernet_rx_buffer_x32.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_ethernet_rx_buffer_x32_if.sv
// rtl/apb_ethernet_rx_buffer_x32_if.sv - APB completer bus for the Ethernet RX frame buffer
interface apb_ethernet_rx_buffer_x32_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
);
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;
   logic                  pslverr;

   modport master (output psel, penable, pwrite, paddr, pwdata,
                   input  prdata, pready, pslverr);
   modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                   output prdata, pready, pslverr);
endinterface

// File: rtl/apb_ethernet_rx_buffer_x32.sv
// rtl/apb_ethernet_rx_buffer_x32.sv - circular RX frame buffer with length FIFO, read and popped over APB
module apb_ethernet_rx_buffer_x32 #(
   parameter int DATA_DEPTH = 1024,
   parameter int HDR_DEPTH  = 32,
   parameter int MAX_FRAME  = 1536,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
) (
   input  logic                        pclk,
   input  logic                        preset_n,
   apb_ethernet_rx_buffer_x32_if.slave apb,
   input  logic                        rx_start,
   input  logic                        rx_data_valid,
   input  logic [31:0]                 rx_data,
   input  logic [2:0]                  rx_bytes_valid,
   input  logic                        rx_commit,
   input  logic                        rx_drop
);
   localparam int PW = $clog2(DATA_DEPTH);
   localparam int HW = $clog2(HDR_DEPTH);
   localparam int LW = 11;

   if (DATA_WIDTH != 32) begin : g_bad_width
      $error("apb_ethernet_rx_buffer_x32: DATA_WIDTH must be 32");
   end

   logic [31:0]   mem [DATA_DEPTH];
   logic [LW-1:0] len_fifo [HDR_DEPTH];
   logic [PW-1:0] head_ptr, commit_ptr, wr_ptr;
   logic [LW-1:0] len;
   logic          dropping;
   logic [HW-1:0] lf_rd, lf_wr;
   logic [HW:0]   lf_cnt;
   logic [15:0]   drops;
   logic          rd_pend;
   logic [31:0]   rd_data;

   // Head-frame view used by both the register file and RX_BUF bounds check
   logic          frame_avail;
   logic [LW-1:0] head_len;
   logic [LW:0]   len_round;
   logic [LW-2:0] head_words;
   assign frame_avail = (lf_cnt != '0);
   assign head_len    = frame_avail ? len_fifo[lf_rd] : '0;
   assign len_round   = {1'b0, head_len} + (LW+1)'(3);
   assign head_words  = len_round[LW:2];

   logic                  access, is_buf, buf_rd, err_c;
   logic [1:0]            reg_idx;
   logic [ADDR_WIDTH-1:0] paddr_sub;
   logic [ADDR_WIDTH-3:0] buf_off;
   logic                  rd_go, pop_go, clr_go;
   logic [31:0]           rd_mux;

   assign access    = apb.psel && apb.penable;
   assign is_buf    = |apb.paddr[ADDR_WIDTH-1:4];
   assign reg_idx   = apb.paddr[3:2];
   assign paddr_sub = apb.paddr - ADDR_WIDTH'(16);
   assign buf_off   = paddr_sub[ADDR_WIDTH-1:2];

   always_comb begin
      err_c  = 1'b0;
      buf_rd = 1'b0;
      if (is_buf) begin
         if (apb.pwrite || !frame_avail || !(32'(buf_off) < 32'(head_words)))
            err_c = 1'b1;
         else
            buf_rd = 1'b1;
      end else begin
         case (reg_idx)
            2'd0, 2'd1: err_c = apb.pwrite;
            2'd2:       err_c = !apb.pwrite || !frame_avail;
            default:    err_c = 1'b0;
         endcase
      end
   end

   always_comb begin
      rd_mux = '0;
      if (is_buf) begin
         rd_mux = {rd_data[7:0], rd_data[15:8], rd_data[23:16], rd_data[31:24]};
      end else begin
         case (reg_idx)
            2'd0:    rd_mux = {16'h0, 8'(lf_cnt), 7'h0, frame_avail};
            2'd1:    rd_mux = {21'h0, head_len};
            2'd3:    rd_mux = {16'h0, drops};
            default: rd_mux = '0;
         endcase
      end
   end

   assign rd_go       = access && buf_rd && !rd_pend;
   assign pop_go      = access && apb.pwrite && !is_buf && reg_idx == 2'd2 && frame_avail;
   assign clr_go      = access && apb.pwrite && !is_buf && reg_idx == 2'd3;
   assign apb.pready  = preset_n && access && (!buf_rd || rd_pend);
   assign apb.pslverr = preset_n && access && err_c;
   assign apb.prdata  = (apb.pready && !apb.pwrite && !err_c) ? rd_mux : '0;

   // Receive side: a data word in the commit cycle is folded in before the commit decision
   logic [LW:0]   len_sum;
   logic          fits, wr_en, push, commit_bad, drop_nxt;
   logic [PW-1:0] wr_nxt;
   logic [LW-1:0] len_nxt;
   assign len_sum = {1'b0, len} + (LW+1)'(rx_bytes_valid);
   assign fits    = ((wr_ptr + PW'(1)) != head_ptr) && (len_sum <= (LW+1)'(MAX_FRAME));

   always_comb begin
      wr_nxt   = wr_ptr;
      len_nxt  = len;
      drop_nxt = dropping;
      wr_en    = 1'b0;
      if (rx_start) begin
         wr_nxt   = commit_ptr;
         len_nxt  = '0;
         drop_nxt = 1'b0;
      end else if (rx_data_valid && !dropping) begin
         if (!fits) begin
            drop_nxt = 1'b1;
         end else begin
            wr_en   = 1'b1;
            wr_nxt  = wr_ptr + PW'(1);
            len_nxt = len_sum[LW-1:0];
         end
      end
      if (rx_drop)
         wr_nxt = commit_ptr;
   end

   assign push       = rx_commit && !drop_nxt && (lf_cnt != (HW+1)'(HDR_DEPTH)) && (len_nxt != '0);
   assign commit_bad = rx_commit && !push;

   always_ff @(posedge pclk) begin
      if (wr_en)
         mem[wr_ptr] <= rx_data;
      if (rd_go)
         rd_data <= mem[head_ptr + PW'(buf_off)];
      if (push)
         len_fifo[lf_wr] <= len_nxt;
   end

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         head_ptr   <= '0;
         commit_ptr <= '0;
         wr_ptr     <= '0;
         len        <= '0;
         dropping   <= 1'b0;
         lf_rd      <= '0;
         lf_wr      <= '0;
         lf_cnt     <= '0;
         drops      <= '0;
         rd_pend    <= 1'b0;
      end else begin
         wr_ptr   <= wr_nxt;
         len      <= len_nxt;
         dropping <= drop_nxt;
         rd_pend  <= rd_go;
         if (push) begin
            commit_ptr <= wr_nxt;
            lf_wr      <= lf_wr + HW'(1);
         end
         if (pop_go) begin
            head_ptr <= head_ptr + PW'(head_words);
            lf_rd    <= lf_rd + HW'(1);
         end
         if (push && !pop_go)
            lf_cnt <= lf_cnt + (HW+1)'(1);
         else if (pop_go && !push)
            lf_cnt <= lf_cnt - (HW+1)'(1);
         if (clr_go)
            drops <= '0;
         else if (commit_bad && drops != 16'hFFFF)
            drops <= drops + 16'd1;
      end
   end

   logic unused_ok;
   assign unused_ok = ^{apb.pwdata, apb.paddr[1:0], paddr_sub[1:0], len_round[1:0]};
endmodule

// File: tb/tb_apb_ethernet_rx_buffer_x32.sv
// tb/tb_apb_ethernet_rx_buffer_x32.sv - scoreboard bench for the APB Ethernet RX frame buffer
module tb_apb_ethernet_rx_buffer_x32;
   logic        pclk = 1'b0;
   always #5 pclk = ~pclk;

   logic        preset_n;
   logic        rx_start, rx_data_valid, rx_commit, rx_drop;
   logic [31:0] rx_data;
   logic [2:0]  rx_bytes_valid;
   logic        psel, penable, pwrite;
   logic [15:0] paddr;
   logic [31:0] pwdata;
   logic        sel;

   apb_ethernet_rx_buffer_x32_if apb_b ();
   apb_ethernet_rx_buffer_x32_if apb_s ();
   assign apb_b.psel = psel;  assign apb_b.penable = penable; assign apb_b.pwrite = pwrite;
   assign apb_b.paddr = paddr; assign apb_b.pwdata = pwdata;
   assign apb_s.psel = psel;  assign apb_s.penable = penable; assign apb_s.pwrite = pwrite;
   assign apb_s.paddr = paddr; assign apb_s.pwdata = pwdata;

   apb_ethernet_rx_buffer_x32 #(.DATA_DEPTH(1024)) dut_b (
      .pclk(pclk), .preset_n(preset_n), .apb(apb_b),
      .rx_start(rx_start), .rx_data_valid(rx_data_valid), .rx_data(rx_data),
      .rx_bytes_valid(rx_bytes_valid), .rx_commit(rx_commit), .rx_drop(rx_drop));

   apb_ethernet_rx_buffer_x32 #(.DATA_DEPTH(16)) dut_s (
      .pclk(pclk), .preset_n(preset_n), .apb(apb_s),
      .rx_start(rx_start), .rx_data_valid(rx_data_valid), .rx_data(rx_data),
      .rx_bytes_valid(rx_bytes_valid), .rx_commit(rx_commit), .rx_drop(rx_drop));

   logic [31:0] prdata_m;
   logic        pready_m, pslverr_m;
   assign prdata_m  = sel ? apb_s.prdata  : apb_b.prdata;
   assign pready_m  = sel ? apb_s.pready  : apb_b.pready;
   assign pslverr_m = sel ? apb_s.pslverr : apb_b.pslverr;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_word_q[$];
   int          exp_len_q[$];

   initial begin
      #1000000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic do_reset();
      preset_n = 1'b0;
      rx_start = 0; rx_data_valid = 0; rx_commit = 0; rx_drop = 0;
      rx_data = '0; rx_bytes_valid = '0;
      psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
      repeat (2) @(posedge pclk);
      #1 preset_n = 1'b1;
      exp_word_q.delete();
      exp_len_q.delete();
   endtask

   task automatic apb_xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err, output int waits);
      @(posedge pclk); #1;
      psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = wdata;
      @(posedge pclk); #1;
      penable = 1; waits = 0;
      #1;
      while (pready_m !== 1'b1 && waits < 8) begin
         @(posedge pclk); #2;
         waits++;
      end
      if (pready_m !== 1'b1) begin
         total++; bad++;
         $display("FAIL apb_timeout addr=%h got pready=%b want 1", addr, pready_m);
      end
      rdata = prdata_m;
      err   = pslverr_m;
      @(posedge pclk); #1;
      psel = 0; penable = 0; pwrite = 0;
   endtask

   // Frame bytes are base+index; bytes beyond nbytes in the last word are driven as zero
   task automatic send_frame(input int nbytes, input logic [7:0] base, input bit commit, input bit expect_ok);
      int nw;
      int vb;
      logic [31:0] d;
      nw = (nbytes + 3) / 4;
      @(posedge pclk); #1; rx_start = 1;
      @(posedge pclk); #1; rx_start = 0;
      for (int w = 0; w < nw; w++) begin
         d  = '0;
         vb = (nbytes - 4*w >= 4) ? 4 : nbytes - 4*w;
         for (int b = 0; b < vb; b++) d[31-8*b -: 8] = base + 8'(4*w + b);
         rx_data_valid = 1; rx_data = d; rx_bytes_valid = 3'(vb);
         rx_commit = commit && (w == nw - 1);
         if (expect_ok) exp_word_q.push_back({d[7:0], d[15:8], d[23:16], d[31:24]});
         @(posedge pclk); #1;
      end
      rx_data_valid = 0; rx_commit = 0; rx_data = '0; rx_bytes_valid = '0;
      if (!commit) begin
         rx_drop = 1;
         @(posedge pclk); #1;
         rx_drop = 0;
      end
      if (expect_ok) exp_len_q.push_back(nbytes);
   endtask

   task automatic test_reset();
      logic [31:0] r; logic e; int wt;
      sel = 0;
      do_reset();
      total++;
      if (pready_m !== 1'b0 || pslverr_m !== 1'b0 || prdata_m !== 32'h0) begin
         bad++; $display("FAIL reset_outputs got pready=%b pslverr=%b prdata=%h want 0 0 0", pready_m, pslverr_m, prdata_m);
      end
      apb_xfer(0, 16'h00, 0, r, e, wt); total++;
      if (r !== 32'h0 || e !== 1'b0) begin bad++; $display("FAIL reset_stat got=%h err=%b want 0", r, e); end
      apb_xfer(0, 16'h04, 0, r, e, wt); total++;
      if (r !== 32'h0 || e !== 1'b0) begin bad++; $display("FAIL reset_len got=%h err=%b want 0", r, e); end
      apb_xfer(0, 16'h0C, 0, r, e, wt); total++;
      if (r !== 32'h0 || e !== 1'b0) begin bad++; $display("FAIL reset_drops got=%h err=%b want 0", r, e); end
   endtask

   task automatic test_basic();
      logic [31:0] r; logic e; int wt; int elen; logic [31:0] ew;
      send_frame(64, 8'h00, 1, 1);
      apb_xfer(0, 16'h00, 0, r, e, wt); total++;
      if (r !== 32'h101) begin bad++; $display("FAIL basic_stat got=%h want 101", r); end
      elen = exp_len_q.pop_front();
      apb_xfer(0, 16'h04, 0, r, e, wt); total++;
      if (r !== 32'(elen)) begin bad++; $display("FAIL basic_len got=%0d want %0d", r, elen); end
      for (int k = 0; k < (elen + 3) / 4; k++) begin
         ew = exp_word_q.pop_front();
         apb_xfer(0, 16'(16 + 4*k), 0, r, e, wt); total++;
         if (r !== ew || e !== 1'b0 || wt !== 1) begin
            bad++; $display("FAIL basic_word%0d got=%h err=%b waits=%0d want %h 0 1", k, r, e, wt, ew);
         end
      end
      apb_xfer(1, 16'h08, 0, r, e, wt); total++;
      if (e !== 1'b0) begin bad++; $display("FAIL basic_pop_err got=%b want 0", e); end
      apb_xfer(0, 16'h00, 0, r, e, wt); total++;
      if (r !== 32'h0) begin bad++; $display("FAIL basic_stat_after_pop got=%h want 0", r); end
   endtask

   task automatic test_partial();
      logic [31:0] r; logic e; int wt; int elen; logic [31:0] ew;
      send_frame(61, 8'h40, 1, 1);
      elen = exp_len_q.pop_front();
      apb_xfer(0, 16'h04, 0, r, e, wt); total++;
      if (r !== 32'(elen)) begin bad++; $display("FAIL partial_len got=%0d want %0d", r, elen); end
      for (int k = 0; k < (elen + 3) / 4; k++) begin
         ew = exp_word_q.pop_front();
         apb_xfer(0, 16'(16 + 4*k), 0, r, e, wt); total++;
         if (r !== ew || e !== 1'b0) begin
            bad++; $display("FAIL partial_word%0d got=%h err=%b want %h 0", k, r, e, ew);
         end
      end
      apb_xfer(0, 16'h50, 0, r, e, wt); total++;
      if (e !== 1'b1 || wt !== 0) begin bad++; $display("FAIL partial_oob got err=%b waits=%0d want 1 0", e, wt); end
      apb_xfer(1, 16'h08, 0, r, e, wt);
   endtask

   task automatic test_drop();
      logic [31:0] r; logic e; int wt; int elen; logic [31:0] ew;
      send_frame(20, 8'h90, 0, 0);
      send_frame(32, 8'hA0, 1, 1);
      apb_xfer(0, 16'h00, 0, r, e, wt); total++;
      if (r !== 32'h101) begin bad++; $display("FAIL drop_stat got=%h want 101", r); end
      apb_xfer(0, 16'h0C, 0, r, e, wt); total++;
      if (r !== 32'h0) begin bad++; $display("FAIL drop_drops got=%h want 0", r); end
      elen = exp_len_q.pop_front();
      apb_xfer(0, 16'h04, 0, r, e, wt); total++;
      if (r !== 32'(elen)) begin bad++; $display("FAIL drop_len got=%0d want %0d", r, elen); end
      for (int k = 0; k < (elen + 3) / 4; k++) begin
         ew = exp_word_q.pop_front();
         apb_xfer(0, 16'(16 + 4*k), 0, r, e, wt); total++;
         if (r !== ew) begin bad++; $display("FAIL drop_word%0d got=%h want %h", k, r, ew); end
      end
      apb_xfer(1, 16'h08, 0, r, e, wt);
   endtask

   task automatic test_wrap();
      logic [31:0] r; logic e; int wt; int elen; logic [31:0] ew;
      sel = 1;
      do_reset();
      send_frame(40, 8'h00, 1, 1);
      send_frame(40, 8'h50, 1, 0);
      apb_xfer(0, 16'h00, 0, r, e, wt); total++;
      if (r !== 32'h101) begin bad++; $display("FAIL wrap_stat got=%h want 101", r); end
      apb_xfer(0, 16'h0C, 0, r, e, wt); total++;
      if (r !== 32'h1) begin bad++; $display("FAIL wrap_drops got=%h want 1", r); end
      for (int f = 0; f < 2; f++) begin
         elen = exp_len_q.pop_front();
         apb_xfer(0, 16'h04, 0, r, e, wt); total++;
         if (r !== 32'(elen)) begin bad++; $display("FAIL wrap_len%0d got=%0d want %0d", f, r, elen); end
         for (int k = 0; k < (elen + 3) / 4; k++) begin
            ew = exp_word_q.pop_front();
            apb_xfer(0, 16'(16 + 4*k), 0, r, e, wt); total++;
            if (r !== ew || e !== 1'b0) begin
               bad++; $display("FAIL wrap_f%0d_word%0d got=%h err=%b want %h 0", f, k, r, e, ew);
            end
         end
         apb_xfer(1, 16'h08, 0, r, e, wt); total++;
         if (e !== 1'b0) begin bad++; $display("FAIL wrap_pop%0d got err=%b want 0", f, e); end
         if (f == 0) send_frame(40, 8'h80, 1, 1);
      end
      sel = 0;
   endtask

   task automatic test_hdr_full();
      logic [31:0] r; logic e; int wt;
      sel = 0;
      do_reset();
      for (int i = 0; i < 33; i++) send_frame(4, 8'(i), 1, 0);
      apb_xfer(0, 16'h00, 0, r, e, wt); total++;
      if (r !== 32'h2001) begin bad++; $display("FAIL hdr_stat got=%h want 2001", r); end
      apb_xfer(0, 16'h0C, 0, r, e, wt); total++;
      if (r !== 32'h1) begin bad++; $display("FAIL hdr_drops got=%h want 1", r); end
      apb_xfer(1, 16'h0C, 32'hFFFF_FFFF, r, e, wt); total++;
      if (e !== 1'b0) begin bad++; $display("FAIL hdr_clr_err got=%b want 0", e); end
      apb_xfer(0, 16'h0C, 0, r, e, wt); total++;
      if (r !== 32'h0) begin bad++; $display("FAIL hdr_drops_cleared got=%h want 0", r); end
   endtask

   task automatic test_errors();
      logic [31:0] r; logic e; int wt;
      do_reset();
      apb_xfer(1, 16'h08, 0, r, e, wt); total++;
      if (e !== 1'b1) begin bad++; $display("FAIL err_pop_empty got=%b want 1", e); end
      apb_xfer(0, 16'h00, 0, r, e, wt); total++;
      if (r !== 32'h0) begin bad++; $display("FAIL err_stat_after_pop got=%h want 0", r); end
      apb_xfer(1, 16'h00, 32'h1, r, e, wt); total++;
      if (e !== 1'b1) begin bad++; $display("FAIL err_write_stat got=%b want 1", e); end
      apb_xfer(0, 16'h08, 0, r, e, wt); total++;
      if (e !== 1'b1) begin bad++; $display("FAIL err_read_pop got=%b want 1", e); end
      apb_xfer(0, 16'h10, 0, r, e, wt); total++;
      if (e !== 1'b1 || wt !== 0) begin bad++; $display("FAIL err_buf_empty got err=%b waits=%0d want 1 0", e, wt); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] r; logic e; int wt;
      send_frame(8, 8'h10, 1, 0);
      @(posedge pclk); #1; rx_start = 1;
      @(posedge pclk); #1; rx_start = 0; rx_data_valid = 1; rx_data = 32'hDEADBEEF; rx_bytes_valid = 3'd4;
      psel = 1; pwrite = 0; paddr = 16'h00;
      @(posedge pclk); #1; penable = 1;
      #1; total++;
      if (pready_m !== 1'b1 || prdata_m !== 32'h101) begin
         bad++; $display("FAIL mid_stat_before got pready=%b prdata=%h want 1 101", pready_m, prdata_m);
      end
      #2 preset_n = 1'b0;
      #1; total++;
      if (pready_m !== 1'b0 || pslverr_m !== 1'b0 || prdata_m !== 32'h0) begin
         bad++; $display("FAIL mid_reset_outputs got pready=%b pslverr=%b prdata=%h want 0 0 0", pready_m, pslverr_m, prdata_m);
      end
      psel = 0; penable = 0; rx_data_valid = 0; rx_data = '0; rx_bytes_valid = '0;
      @(posedge pclk); #1 preset_n = 1'b1;
      apb_xfer(0, 16'h00, 0, r, e, wt); total++;
      if (r !== 32'h0) begin bad++; $display("FAIL mid_stat_after got=%h want 0", r); end
   endtask

   initial begin
      sel = 0;
      test_reset();
      test_basic();
      test_partial();
      test_drop();
      test_wrap();
      test_hdr_full();
      test_errors();
      test_reset_mid();
      if (exp_len_q.size() != 0) begin
         total++; bad++; $display("FAIL scoreboard_leftover got=%0d want 0", exp_len_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
